// File: rtl/iram_ctrl_pkg.sv
// iram_ctrl_pkg
//   Shared constants and types for the instruction-RAM refill controller.
//   - iram_state_t    : refill FSM states (IDLE, FILL, DONE)
//   - IRAM_LINE_WORDS : default number of 32-bit words in one cache line
package iram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } iram_state_t;

  localparam int IRAM_LINE_WORDS = 4;

endpackage

// File: rtl/iram_ctrl.sv
// iram_ctrl
//   Responder side of the fetch unit's cache-miss refill interface. On a
//   miss it fetches one aligned cache line from instruction memory and hands
//   the words back to the fetch unit one at a time.
//
// Ports
//   clk          in   clock
//   nrst         in   synchronous active-low reset
//   miss_cache   in   refill request from the core (level)
//   ram_address  in   missing byte address, any alignment within the line
//   mem_word     out  refill word to the fetch unit
//   word_ready   out  one-cycle pulse: mem_word/word_offset valid
//   word_offset  out  index of mem_word within the line
//   busy         out  refill in progress (state != IDLE)
//   mem_req      out  read request to IRAM
//   mem_addr     out  word-aligned byte address of the request
//   mem_gnt      in   IRAM accepted the request (mem_req & mem_gnt)
//   mem_rvalid   in   read data valid, responses return in request order
//   mem_rdata    in   read data
module iram_ctrl
  import iram_ctrl_pkg::*;
#(
  parameter int PC_SIZE    = 32,
  parameter int WORD_SIZE  = 32,
  parameter int LINE_WORDS = IRAM_LINE_WORDS
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          miss_cache,
  input  logic [PC_SIZE-1:0]            ram_address,
  output logic [WORD_SIZE-1:0]          mem_word,
  output logic                          word_ready,
  output logic [$clog2(LINE_WORDS)-1:0] word_offset,
  output logic                          busy,
  output logic                          mem_req,
  output logic [PC_SIZE-1:0]            mem_addr,
  input  logic                          mem_gnt,
  input  logic                          mem_rvalid,
  input  logic [WORD_SIZE-1:0]          mem_rdata
);

  localparam int OFF_W    = $clog2(LINE_WORDS);
  localparam int CNT_W    = OFF_W + 1;
  localparam int LINE_LSB = OFF_W + 2;

  localparam logic [CNT_W-1:0]   LAST_CNT  = CNT_W'(LINE_WORDS);
  localparam logic [PC_SIZE-1:0] LINE_MASK = PC_SIZE'((64'd1 << LINE_LSB) - 64'd1);

  iram_state_t          state_q, state_d;
  logic [PC_SIZE-1:0]   base_q, base_d;
  logic [CNT_W-1:0]     req_cnt_q, req_cnt_d;
  logic [CNT_W-1:0]     rsp_cnt_q, rsp_cnt_d;
  logic                 mem_req_q, mem_req_d;
  logic [PC_SIZE-1:0]   mem_addr_q, mem_addr_d;
  logic [WORD_SIZE-1:0] mem_word_q, mem_word_d;
  logic                 word_ready_q, word_ready_d;
  logic [OFF_W-1:0]     word_offset_q, word_offset_d;
  logic                 busy_q, busy_d;

  logic                 accept_req;
  logic                 accept_rsp;

  // A request counts only when IRAM grants it; a response counts only while
  // filling and only up to one line, so stale or surplus rvalid is dropped.
  assign accept_req = mem_req_q & mem_gnt;
  assign accept_rsp = (state_q == FILL) && mem_rvalid && (rsp_cnt_q != LAST_CNT);

  // Next-state logic for the refill FSM, the two counters and every
  // registered output. mem_req/mem_addr only move on a grant, so they stay
  // stable under backpressure; the request and response sides run
  // independently, allowing up to a full line in flight.
  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    req_cnt_d     = req_cnt_q;
    rsp_cnt_d     = rsp_cnt_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    mem_word_d    = mem_word_q;
    word_ready_d  = 1'b0;
    word_offset_d = word_offset_q;

    unique case (state_q)
      IDLE: begin
        if (miss_cache) begin
          state_d    = FILL;
          base_d     = ram_address & ~LINE_MASK;
          req_cnt_d  = '0;
          rsp_cnt_d  = '0;
          mem_req_d  = 1'b1;
          mem_addr_d = base_d;
        end
      end

      FILL: begin
        if (accept_req) begin
          req_cnt_d = req_cnt_q + 1'b1;
          mem_req_d = (req_cnt_d != LAST_CNT);
          // Leave the last granted address on the bus once the line is fully
          // requested rather than pointing past the end of the line.
          if (req_cnt_d != LAST_CNT) begin
            mem_addr_d = base_q + (PC_SIZE'(req_cnt_d) << 2);
          end
        end
        if (accept_rsp) begin
          mem_word_d    = mem_rdata;
          word_offset_d = rsp_cnt_q[OFF_W-1:0];
          word_ready_d  = 1'b1;
          rsp_cnt_d     = rsp_cnt_q + 1'b1;
          if (rsp_cnt_d == LAST_CNT) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        // Wait for the core to drop its request so one miss gives one refill.
        if (!miss_cache) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset abandons any refill in flight.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q       <= IDLE;
      base_q        <= '0;
      req_cnt_q     <= '0;
      rsp_cnt_q     <= '0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      mem_word_q    <= '0;
      word_ready_q  <= 1'b0;
      word_offset_q <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      req_cnt_q     <= req_cnt_d;
      rsp_cnt_q     <= rsp_cnt_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      mem_word_q    <= mem_word_d;
      word_ready_q  <= word_ready_d;
      word_offset_q <= word_offset_d;
      busy_q        <= busy_d;
    end
  end

  assign mem_word    = mem_word_q;
  assign word_ready  = word_ready_q;
  assign word_offset = word_offset_q;
  assign busy        = busy_q;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;

endmodule

// File: tb/tb_iram_ctrl.sv
// tb_iram_ctrl
//   Bench for iram_ctrl. An in-order IRAM model (latency lat, optional
//   stalls or random grants) answers requests; stimulus pushes the expected
//   request addresses and refill words into queues, and a monitor pops and
//   compares them whenever the DUT grants a request or pulses word_ready.
module tb_iram_ctrl;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        miss_cache = 1'b0;
  logic [31:0] ram_address = '0;
  logic [31:0] mem_word;
  logic        word_ready;
  logic [1:0]  word_offset;
  logic        busy;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b1;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  int vec_cnt = 0;
  int miscompare_cnt = 0;
  int words_seen = 0;

  // IRAM model controls
  int lat = 2;
  bit gnt_rand = 1'b0;
  bit rand_inputs = 1'b0;
  int stall_at = -1;
  int stall_left = 0;
  int gnt_total = 0;
  int neg_cnt = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  off;
  } word_t;

  rsp_t        pend_q[$];
  word_t       exp_q[$];
  logic [31:0] req_q[$];

  always #5 clk = ~clk;

  iram_ctrl #(.PC_SIZE(32), .WORD_SIZE(32), .LINE_WORDS(4)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .miss_cache  (miss_cache),
    .ram_address (ram_address),
    .mem_word    (mem_word),
    .word_ready  (word_ready),
    .word_offset (word_offset),
    .busy        (busy),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata)
  );

  // Memory contents: 0x20 -> C0FE_FFDF, 0x2C -> C0F2_FFD3.
  function automatic logic [31:0] model_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, ~a[15:0]};
  endfunction

  // IRAM model: drives grant and response at the negative edge. A request
  // seen granted here is accepted at the next posedge and its data is
  // presented lat cycles later, strictly in order.
  always @(negedge clk) begin
    neg_cnt++;
    if (rand_inputs) begin
      mem_rvalid = 1'($urandom_range(0, 1));
      mem_rdata  = $urandom();
      mem_gnt    = 1'($urandom_range(0, 1));
    end else begin
      if (pend_q.size() > 0 && pend_q[0].due <= neg_cnt) begin
        mem_rvalid = 1'b1;
        mem_rdata  = model_word(pend_q[0].addr);
        void'(pend_q.pop_front());
      end else begin
        mem_rvalid = 1'b0;
        mem_rdata  = 32'hDEAD_BEEF;
      end
      if (stall_left > 0 && gnt_total == stall_at && mem_req) begin
        mem_gnt = 1'b0;
        stall_left--;
      end else if (gnt_rand) begin
        mem_gnt = 1'($urandom_range(0, 1));
      end else begin
        mem_gnt = 1'b1;
      end
      if (mem_req && mem_gnt) begin
        pend_q.push_back('{addr: mem_addr, due: neg_cnt + lat});
        gnt_total++;
      end
    end
  end

  // Monitor: checks granted/held request addresses and every refill word
  // against the scoreboard queues.
  word_t       mon_w;
  logic [31:0] mon_a;
  always begin
    @(negedge clk);
    #1;
    if (nrst && mem_req && mem_gnt) begin
      vec_cnt++;
      if (req_q.size() == 0) begin
        miscompare_cnt++;
        $display("[TB] FAIL req_unexpected: mem_addr=%h granted, none required", mem_addr);
      end else begin
        mon_a = req_q.pop_front();
        if (mem_addr !== mon_a) begin
          miscompare_cnt++;
          $display("[TB] FAIL req_addr: got %h required %h", mem_addr, mon_a);
        end
      end
    end else if (nrst && mem_req && req_q.size() > 0) begin
      vec_cnt++;
      if (mem_addr !== req_q[0]) begin
        miscompare_cnt++;
        $display("[TB] FAIL req_hold: got %h required %h", mem_addr, req_q[0]);
      end
    end
    if (word_ready) begin
      words_seen++;
      vec_cnt++;
      if (exp_q.size() == 0) begin
        miscompare_cnt++;
        $display("[TB] FAIL word_unexpected: data=%h offset=%0d, no word required", mem_word, word_offset);
      end else begin
        mon_w = exp_q.pop_front();
        if (mem_word !== mon_w.data || word_offset !== mon_w.off) begin
          miscompare_cnt++;
          $display("[TB] FAIL word: got %h/%0d required %h/%0d", mem_word, word_offset, mon_w.data, mon_w.off);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vec_cnt++;
    if (actual !== expected) begin
      miscompare_cnt++;
      $display("[TB] FAIL %s: got %h required %h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [31:0] addr);
    logic [31:0] base;
    base = addr & ~32'hF;
    miss_cache  = 1'b1;
    ram_address = addr;
    for (int i = 0; i < 4; i++) begin
      req_q.push_back(base + 32'(4 * i));
      exp_q.push_back('{data: model_word(base + 32'(4 * i)), off: 2'(i)});
    end
  endtask

  task automatic wait_line_done(input int budget);
    int n;
    n = 0;
    while ((req_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
      step();
      n++;
    end
    if (req_q.size() > 0 || exp_q.size() > 0) begin
      vec_cnt++;
      miscompare_cnt++;
      $display("[TB] FAIL line_timeout: %0d requests and %0d words outstanding, required 0", req_q.size(), exp_q.size());
      req_q.delete();
      exp_q.delete();
    end
  endtask

  task automatic wait_words(input int target, input int budget);
    int n;
    n = 0;
    while (words_seen < target && n < budget) begin
      step();
      n++;
    end
    if (words_seen < target) begin
      vec_cnt++;
      miscompare_cnt++;
      $display("[TB] FAIL word_timeout: %0d words seen, required %0d", words_seen, target);
    end
  endtask

  task automatic end_miss();
    miss_cache = 1'b0;
    step();
    step();
  endtask

  initial begin
    int first_req;
    int first_wr;
    int last_wr;
    int stall_cnt;
    int w0;

    // Reset with random inputs
    rand_inputs = 1'b1;
    for (int i = 0; i < 3; i++) begin
      miss_cache  = 1'($urandom_range(0, 1));
      ram_address = $urandom();
      step();
    end
    check_output("rst_mem_word", mem_word, 32'h0);
    check_output("rst_word_ready", 32'(word_ready), 32'h0);
    check_output("rst_mem_req", 32'(mem_req), 32'h0);
    check_output("rst_busy", 32'(busy), 32'h0);
    check_output("rst_mem_addr", mem_addr, 32'h0);
    rand_inputs = 1'b0;
    miss_cache  = 1'b0;
    ram_address = '0;
    step();
    nrst = 1'b1;
    step();

    // Basic refill, L=2, miss at 0x24
    lat = 2;
    apply_stimulus(32'h0000_0024);
    first_req = -1;
    first_wr  = -1;
    last_wr   = -1;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (mem_req && first_req < 0) first_req = k;
      if (k >= 1 && k <= 4) check_output("basic_addr", mem_addr, 32'h20 + 32'(4 * (k - 1)));
      if (word_ready) begin
        if (first_wr < 0) begin
          first_wr = k;
          check_output("basic_word0", mem_word, 32'hC0FE_FFDF);
        end
        last_wr = k;
        if (word_offset == 2'd3) check_output("basic_word3", mem_word, 32'hC0F2_FFD3);
      end
    end
    check_output("basic_first_req_cycle", 32'(first_req), 32'd1);
    check_output("basic_first_word_cycle", 32'(first_wr), 32'd4);
    check_output("basic_last_word_cycle", 32'(last_wr), 32'd7);
    check_output("basic_done_busy", 32'(busy), 32'h1);
    wait_line_done(5);
    end_miss();
    check_output("basic_idle_busy", 32'(busy), 32'h0);

    // Backpressure: three stall cycles on the 2nd request
    lat = 1;
    stall_at   = gnt_total + 1;
    stall_left = 3;
    stall_cnt  = 0;
    apply_stimulus(32'h0000_0020);
    for (int k = 0; k < 30 && (req_q.size() > 0 || exp_q.size() > 0); k++) begin
      step();
      if (mem_req && !mem_gnt) begin
        stall_cnt++;
        check_output("stall_addr", mem_addr, 32'h24);
      end
    end
    check_output("stall_cycles", 32'(stall_cnt), 32'd3);
    wait_line_done(5);
    end_miss();

    // Early abort: miss drops after the first word
    lat = 2;
    w0 = words_seen;
    apply_stimulus(32'h0000_0088);
    wait_words(w0 + 1, 20);
    miss_cache = 1'b0;
    wait_line_done(20);
    check_output("abort_words", 32'(words_seen - w0), 32'd4);
    check_output("abort_done_busy", 32'(busy), 32'h1);
    step();
    step();
    check_output("abort_idle_busy", 32'(busy), 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      check_output("abort_no_req", 32'(mem_req), 32'h0);
    end

    // Handshake: miss held high after the line
    apply_stimulus(32'h0000_0300);
    wait_line_done(20);
    for (int k = 0; k < 5; k++) begin
      step();
      check_output("hold_busy", 32'(busy), 32'h1);
      check_output("hold_no_req", 32'(mem_req), 32'h0);
    end
    miss_cache = 1'b0;
    step();
    check_output("hs_idle_busy", 32'(busy), 32'h0);
    apply_stimulus(32'h0000_0100);
    wait_line_done(20);
    end_miss();

    // Reset in the middle of a refill after two words
    lat = 3;
    w0 = words_seen;
    apply_stimulus(32'h0000_0200);
    wait_words(w0 + 2, 20);
    nrst = 1'b0;
    miss_cache = 1'b0;
    req_q.delete();
    exp_q.delete();
    step();
    check_output("mid_rst_mem_word", mem_word, 32'h0);
    check_output("mid_rst_word_ready", 32'(word_ready), 32'h0);
    check_output("mid_rst_mem_req", 32'(mem_req), 32'h0);
    check_output("mid_rst_busy", 32'(busy), 32'h0);
    check_output("mid_rst_offset", 32'(word_offset), 32'h0);
    nrst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check_output("stale_busy", 32'(busy), 32'h0);
    end
    lat = 2;
    apply_stimulus(32'h0000_0040);
    wait_line_done(20);
    end_miss();

    // Random grants on the last line of the address space
    lat = 1;
    gnt_rand = 1'b1;
    apply_stimulus(32'hFFFF_FFFA);
    wait_line_done(200);
    gnt_rand = 1'b0;
    end_miss();
    check_output("final_busy", 32'(busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
